// File: rtl/dcmi_tx.sv
// Camera-side DCMI transmitter: emits vsync/hsync/data frames with programmable geometry.
// Optional embedded BT.656-style sync codes when DCMI_TX_EMBSYNC_EN is defined.
module dcmi_tx #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 14
) (
`ifdef DCMI_TX_EMBSYNC_EN
  input  logic          embsync,
`endif
  input  logic          clk,
  input  logic          rstn,
  input  logic          tx_en,
  input  logic          continuous,
  input  logic [3:0]    pclk_div,
  input  logic [CW-1:0] hsize,
  input  logic [CW-1:0] vsize,
  input  logic [CW-1:0] hblank,
  input  logic [CW-1:0] vs_width,
  input  logic [CW-1:0] vbp,
  input  logic [CW-1:0] vfp,
  input  logic          hspol,
  input  logic          vspol,
  output logic          pix_stb,
  output logic          dcmi_vsync,
  output logic          dcmi_hsync,
  output logic [DW-1:0] dcmi_data,
  output logic          busy,
  output logic          vsync_pulse,
  output logic          line_end_pulse,
  output logic          frame_end_pulse
);

  typedef enum logic [2:0] {StIdle, StVs, StVbp, StLine, StHb, StVfp} state_e;

  state_e        state_q;
  logic [3:0]    div_q;
  logic [CW-1:0] cnt_q, pix_q, line_q;
  logic          tx_en_q, vs_q, href_q;
  logic [DW-1:0] data_q;

  logic [3:0]    div_sh;
  logic [CW-1:0] hsize_sh, vsize_sh, hblank_sh, vsw_sh, vbp_sh, vfp_sh;
  logic          hspol_sh, vspol_sh;
  logic          emb_on, frame_start, hpol_eff, vpol_eff;

  assign busy    = (state_q != StIdle);
  assign pix_stb = busy && (div_q == div_sh);

  // A frame starts from IDLE on a tx_en edge (or level in continuous mode), or
  // back-to-back from the final VFP strobe.
  assign frame_start = ((state_q == StIdle) && tx_en && (!tx_en_q || continuous)) ||
                       ((state_q == StVfp) && pix_stb && (cnt_q == vfp_sh) &&
                        tx_en && continuous);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_sh    <= '0;
      hsize_sh  <= '0;
      vsize_sh  <= '0;
      hblank_sh <= '0;
      vsw_sh    <= '0;
      vbp_sh    <= '0;
      vfp_sh    <= '0;
      hspol_sh  <= 1'b0;
      vspol_sh  <= 1'b0;
    end else if (frame_start) begin
      div_sh    <= pclk_div;
      hsize_sh  <= hsize;
      vsize_sh  <= vsize;
      hblank_sh <= hblank;
      vsw_sh    <= vs_width;
      vbp_sh    <= vbp;
      vfp_sh    <= vfp;
      hspol_sh  <= hspol;
      vspol_sh  <= vspol;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      div_q           <= '0;
      cnt_q           <= '0;
      pix_q           <= '0;
      line_q          <= '0;
      tx_en_q         <= 1'b0;
      vs_q            <= 1'b0;
      href_q          <= 1'b0;
      data_q          <= '0;
      vsync_pulse     <= 1'b0;
      line_end_pulse  <= 1'b0;
      frame_end_pulse <= 1'b0;
    end else begin
      tx_en_q         <= tx_en;
      vsync_pulse     <= 1'b0;
      line_end_pulse  <= 1'b0;
      frame_end_pulse <= 1'b0;
      if (frame_start) begin
        state_q     <= StVs;
        div_q       <= '0;
        cnt_q       <= '0;
        pix_q       <= '0;
        line_q      <= '0;
        vs_q        <= 1'b1;
        href_q      <= 1'b0;
        data_q      <= '0;
        vsync_pulse <= 1'b1;
      end else if (state_q != StIdle) begin
        div_q <= pix_stb ? 4'd0 : div_q + 4'd1;
        if (pix_stb) begin
          unique case (state_q)
            StVs: begin
              if (cnt_q == vsw_sh) begin
                state_q <= StVbp;
                cnt_q   <= '0;
                vs_q    <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            StVbp: begin
              if (cnt_q == vbp_sh) begin
                state_q <= StLine;
                cnt_q   <= '0;
                pix_q   <= '0;
                href_q  <= 1'b1;
                data_q  <= DW'(line_q);
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            StLine: begin
              if (pix_q == hsize_sh) begin
                href_q         <= 1'b0;
                data_q         <= '0;
                cnt_q          <= '0;
                line_end_pulse <= 1'b1;
                if (line_q == vsize_sh) begin
                  state_q         <= StVfp;
                  frame_end_pulse <= 1'b1;
                end else begin
                  state_q <= StHb;
                end
              end else begin
                pix_q  <= pix_q + CW'(1);
                data_q <= DW'(pix_q + line_q + CW'(1));
              end
            end
            StHb: begin
              if (cnt_q == hblank_sh) begin
                state_q <= StLine;
                cnt_q   <= '0;
                pix_q   <= '0;
                line_q  <= line_q + CW'(1);
                href_q  <= 1'b1;
                data_q  <= DW'(line_q + CW'(1));
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            StVfp: begin
              if (cnt_q == vfp_sh) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                line_q  <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  // Idle lines follow the live polarity inputs so they read inactive before any frame.
  assign hpol_eff = busy ? hspol_sh : hspol;
  assign vpol_eff = busy ? vspol_sh : vspol;

  assign dcmi_hsync = (href_q & ~emb_on) ^ hpol_eff;
  assign dcmi_vsync = (vs_q & ~emb_on) ^ vpol_eff;

`ifdef DCMI_TX_EMBSYNC_EN
  logic          emb_sh;
  logic          code_hit, code_h;
  logic [1:0]    code_idx;
  logic [7:0]    code_byte;
  logic [CW-1:0] lim;
  logic [DW-1:0] overlay;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      emb_sh <= 1'b0;
    end else if (frame_start) begin
      emb_sh <= embsync;
    end
  end

  assign emb_on = emb_sh;

  // EAV fills the first 4 blank strobes after a line, SAV the last 4 before one.
  always_comb begin
    code_hit = 1'b0;
    code_h   = 1'b0;
    code_idx = 2'd0;
    overlay  = '0;
    unique case (state_q)
      StVbp:   lim = vbp_sh;
      StHb:    lim = hblank_sh;
      default: lim = vfp_sh;
    endcase
    if (emb_sh) begin
      if (((state_q == StHb) || (state_q == StVfp)) && (cnt_q < CW'(4))) begin
        code_hit = 1'b1;
        code_h   = 1'b1;
        code_idx = cnt_q[1:0];
      end else if (((state_q == StVbp) || (state_q == StHb)) &&
                   (cnt_q >= lim - CW'(3))) begin
        code_hit = 1'b1;
        code_idx = 2'(cnt_q - (lim - CW'(3)));
      end
    end
    unique case (code_idx)
      2'd0:    code_byte = 8'hff;
      2'd3:    code_byte = {1'b1, 1'b0, 1'b0, code_h, 4'b0000};
      default: code_byte = 8'h00;
    endcase
    if (code_hit) overlay[DW-1 -: 8] = code_byte;
  end

  assign dcmi_data = data_q | overlay;
`else
  assign emb_on    = 1'b0;
  assign dcmi_data = data_q;
`endif

endmodule
